// File: rtl/ps2_host.sv
// PS/2 host port: debounced open-drain clk/data, receive FIFO with clock inhibit,
// retried command transmit with ACK sampling, classified receive errors.

module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module ps2_host #(
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int REQUEST_CYCLES  = 8191,
  parameter int WATCHDOG_CYCLES = 65535,
  parameter int FIFO_DEPTH      = 8,
  parameter int RETRIES         = 2
) (
  input  logic                          clk,
  input  logic                          reset_low,
  input  logic                          ps2_clk_in,
  output logic                          ps2_clk_out,
  output logic                          ps2_clk_oe,
  input  logic                          ps2_data_in,
  output logic                          ps2_data_out,
  output logic                          ps2_data_oe,
  output logic                          command_ready,
  input  logic                          command_valid,
  input  logic [7:0]                    command_byte,
  input  logic                          command_ack_ready,
  output logic                          command_ack_valid,
  output logic                          command_ack_error,
  input  logic                          scan_code_ready,
  output logic                          scan_code_valid,
  output logic [7:0]                    scan_code_byte,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_error,
  output logic [1:0]                    rx_error_code
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REQUEST_CYCLES > WATCHDOG_CYCLES) ? REQUEST_CYCLES : WATCHDOG_CYCLES;
  localparam int TW  = $clog2(TMAX + 1);
  localparam int ATW = $clog2(RETRIES + 2) + 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, RX, TX_REQ, TX_BITS, TX_ACK, ACK_HOLD} state_t;

  // Index 0 is the clock pin, index 1 the data pin; lines idle high.
  logic [1:0]     pin_raw, s1_q, s2_q, deb_q;
  logic [DBW-1:0] dcnt_q [2];
  logic           clk_prev_q;

  assign pin_raw = {ps2_data_in, ps2_clk_in};

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      s1_q       <= '1;
      s2_q       <= '1;
      deb_q      <= '1;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      s1_q       <= pin_raw;
      s2_q       <= s1_q;
      clk_prev_q <= deb_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]  <= s2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DBW'(1);
        end
      end
    end
  end

  logic clk_fall, clk_rise, data_s;
  assign clk_fall = clk_prev_q & ~deb_q[0];
  assign clk_rise = ~clk_prev_q & deb_q[0];
  assign data_s   = deb_q[1];

  state_t         state_q, state_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [3:0]     bit_q, bit_d;
  logic [8:0]     rx_sr_q, rx_sr_d;
  logic [9:0]     tx_sr_q, tx_sr_d;
  logic [7:0]     byte_q, byte_d;
  logic           wait_rise_q, wait_rise_d;
  logic           ack_bit_q, ack_bit_d;
  logic [ATW-1:0] att_q, att_d;
  logic           cmd_err_q, cmd_err_d;
  logic           rx_err_q, rx_err_d;
  logic [1:0]     rx_code_q, rx_code_d;
  logic           run_q;

  logic fifo_full, fifo_push, fifo_pop, accept, tx_fail, wd_exp;

  assign fifo_full = (rx_count == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
  assign fifo_pop  = scan_code_valid & scan_code_ready;
  assign accept    = command_valid & command_ready;
  assign wd_exp    = (tmr_q == TW'(WATCHDOG_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    tmr_d       = '0;
    bit_d       = bit_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    byte_d      = byte_q;
    wait_rise_d = wait_rise_q;
    ack_bit_d   = ack_bit_q;
    att_d       = att_q;
    cmd_err_d   = cmd_err_q;
    rx_err_d    = 1'b0;
    rx_code_d   = rx_code_q;
    fifo_push   = 1'b0;
    tx_fail     = 1'b0;

    if (state_q inside {RX, TX_REQ, TX_BITS, TX_ACK}) tmr_d = tmr_q + TW'(1);

    case (state_q)
      IDLE, INHIBIT: begin
        if (state_q == IDLE && fifo_full) begin
          state_d = INHIBIT;
        end else if (accept) begin
          state_d   = TX_REQ;
          att_d     = ATW'(1);
          byte_d    = command_byte;
          cmd_err_d = 1'b0;
        end else if (state_q == INHIBIT) begin
          if (!fifo_full) state_d = IDLE;
        end else if (clk_fall && !data_s) begin
          state_d = RX;
        end
      end
      RX: begin
        if (wd_exp) begin
          rx_err_d  = 1'b1;
          rx_code_d = 2'b11;
          state_d   = IDLE;
        end else if (wait_rise_q) begin
          if (clk_rise) state_d = IDLE;
        end else if (clk_fall) begin
          rx_sr_d = {data_s, rx_sr_q[8:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            wait_rise_d = 1'b1;
            if (!(^rx_sr_q)) begin
              rx_err_d  = 1'b1;
              rx_code_d = 2'b01;
            end else if (!data_s) begin
              rx_err_d  = 1'b1;
              rx_code_d = 2'b10;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
      end
      TX_REQ: begin
        if (tmr_q == TW'(REQUEST_CYCLES - 1)) state_d = TX_BITS;
      end
      TX_BITS: begin
        if (wd_exp) begin
          tx_fail = 1'b1;
        end else if (clk_fall) begin
          tx_sr_d = {1'b1, tx_sr_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = TX_ACK;
        end
      end
      TX_ACK: begin
        if (wd_exp) begin
          tx_fail = 1'b1;
        end else if (!wait_rise_q && clk_fall) begin
          ack_bit_d   = ~data_s;
          wait_rise_d = 1'b1;
        end else if (wait_rise_q && clk_rise) begin
          if (ack_bit_q) state_d = ACK_HOLD;
          else           tx_fail = 1'b1;
        end
      end
      ACK_HOLD: begin
        if (command_ack_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tx_fail) begin
      if (att_q <= ATW'(RETRIES)) begin
        att_d   = att_q + ATW'(1);
        state_d = TX_REQ;
      end else begin
        cmd_err_d = 1'b1;
        state_d   = ACK_HOLD;
      end
    end

    // The watchdog spans the whole transmit frame, including the ACK bit.
    if (state_d != state_q) begin
      bit_d       = '0;
      wait_rise_d = 1'b0;
      if (!(state_q == TX_BITS && state_d == TX_ACK)) tmr_d = '0;
      if (state_d == TX_REQ) tx_sr_d = {~^byte_d, byte_d, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      bit_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '1;
      byte_q      <= '0;
      wait_rise_q <= 1'b0;
      ack_bit_q   <= 1'b0;
      att_q       <= '0;
      cmd_err_q   <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_code_q   <= 2'b00;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_q       <= bit_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      byte_q      <= byte_d;
      wait_rise_q <= wait_rise_d;
      ack_bit_q   <= ack_bit_d;
      att_q       <= att_d;
      cmd_err_q   <= cmd_err_d;
      rx_err_q    <= rx_err_d;
      rx_code_q   <= rx_code_d;
      run_q       <= 1'b1;
    end
  end

  ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_low),
    .push_i  (fifo_push),
    .data_i  (rx_sr_q[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (scan_code_byte),
    .count_o (rx_count)
  );

  // A full FIFO in IDLE must inhibit first, so no command is taken that cycle.
  assign command_ready     = run_q & ((state_q == IDLE && !fifo_full) || state_q == INHIBIT);
  assign command_ack_valid = (state_q == ACK_HOLD);
  assign command_ack_error = (state_q == ACK_HOLD) & cmd_err_q;
  assign scan_code_valid   = (rx_count != '0);
  assign ps2_clk_out       = 1'b0;
  assign ps2_clk_oe        = (state_q == INHIBIT) || (state_q == TX_REQ);
  assign ps2_data_oe       = (state_q == TX_REQ) || (state_q == TX_BITS);
  assign ps2_data_out      = tx_sr_q[0];
  assign rx_error          = rx_err_q;
  assign rx_error_code     = rx_code_q;
endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host with a behavioural open-drain PS/2 device.
module tb_ps2_host;
  localparam int DEB = 2, REQ = 40, WD = 600, DEPTH = 4, RET = 2, HP = 12;

  logic clk = 1'b0;
  logic reset_low = 1'b0;
  always #5 clk = ~clk;

  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic clk_line, data_line;
  logic ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
  logic command_ready, command_valid = 1'b0;
  logic [7:0] command_byte = 8'h00;
  logic command_ack_ready = 1'b0, command_ack_valid, command_ack_error;
  logic scan_code_ready = 1'b0, scan_code_valid;
  logic [7:0] scan_code_byte;
  logic [2:0] rx_count;
  logic rx_error;
  logic [1:0] rx_error_code;

  assign clk_line  = ps2_clk_oe  ? (ps2_clk_out & dev_clk)   : dev_clk;
  assign data_line = ps2_data_oe ? (ps2_data_out & dev_data) : dev_data;

  ps2_host #(.DEBOUNCE_CYCLES(DEB), .REQUEST_CYCLES(REQ), .WATCHDOG_CYCLES(WD),
             .FIFO_DEPTH(DEPTH), .RETRIES(RET)) dut (
    .clk(clk), .reset_low(reset_low),
    .ps2_clk_in(clk_line), .ps2_clk_out(ps2_clk_out), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_in(data_line), .ps2_data_out(ps2_data_out), .ps2_data_oe(ps2_data_oe),
    .command_ready(command_ready), .command_valid(command_valid), .command_byte(command_byte),
    .command_ack_ready(command_ack_ready), .command_ack_valid(command_ack_valid),
    .command_ack_error(command_ack_error),
    .scan_code_ready(scan_code_ready), .scan_code_valid(scan_code_valid),
    .scan_code_byte(scan_code_byte), .rx_count(rx_count),
    .rx_error(rx_error), .rx_error_code(rx_error_code)
  );

  int n_tests = 0, n_fail = 0;
  int err_pulses = 0, req_pulses = 0;
  logic oe_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_error) err_pulses++;
    if (ps2_clk_oe && !oe_prev && ps2_data_oe) req_pulses++;
    oe_prev = ps2_clk_oe;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, awaited event not seen", nm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
    logic [10:0] f;
    int t;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    t = 0;
    while (clk_line == 1'b0 && t < 2000) begin cyc(1); t++; end
    if (t >= 2000) timeout_fail("device_wait_clk_release");
    cyc(4);
    for (int k = 0; k < nbits; k++) begin
      dev_data = f[k];
      cyc(HP);
      dev_clk = 1'b0;
      cyc(HP);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    cyc(HP);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk(nm, scan_code_byte, exp);
    scan_code_ready = 1'b1;
    cyc(1);
    scan_code_ready = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] b);
    int t;
    t = 0;
    while (!command_ready && t < 1000) begin cyc(1); t++; end
    if (t >= 1000) timeout_fail("command_ready_wait");
    command_byte  = b;
    command_valid = 1'b1;
    cyc(1);
    command_valid = 1'b0;
  endtask

  task automatic ack_cmd();
    command_ack_ready = 1'b1;
    cyc(1);
    command_ack_ready = 1'b0;
  endtask

  task automatic dev_tx(input logic ack, input int nbits, output logic [9:0] bits,
                        output int req_len, output logic start_lvl);
    int t;
    t = 0;
    bits = '1;
    req_len = 0;
    start_lvl = 1'b1;
    while (!ps2_clk_oe && t < 500) begin cyc(1); t++; end
    if (t >= 500) begin
      timeout_fail("tx_request_wait");
    end else begin
      start_lvl = data_line;
      while (ps2_clk_oe && req_len < 5000) begin cyc(1); req_len++; end
      cyc(10);
      for (int k = 0; k < nbits; k++) begin
        dev_clk = 1'b0;
        cyc(HP);
        dev_clk = 1'b1;
        bits[k] = data_line;
        cyc(HP);
      end
      if (nbits == 10) begin
        dev_data = ~ack;
        cyc(2);
        dev_clk = 1'b0;
        cyc(HP);
        dev_clk = 1'b1;
        cyc(HP);
        dev_data = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       stop;
    int         exp_err;
    logic [1:0] exp_code;
    int         exp_cnt;
    logic [7:0] exp_head;
  } rx_vec_t;

  rx_vec_t vec [5];

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [9:0] bits;
    int rl, e0, p0;
    logic sl;

    vec[0] = '{8'h1C, 1'b0, 1'b1, 0, 2'b00, 1, 8'h1C};
    vec[1] = '{8'h1C, 1'b1, 1'b1, 1, 2'b01, 1, 8'h1C};
    vec[2] = '{8'h1C, 1'b0, 1'b0, 1, 2'b10, 1, 8'h1C};
    vec[3] = '{8'hA5, 1'b1, 1'b0, 1, 2'b01, 1, 8'h1C};
    vec[4] = '{8'h00, 1'b0, 1'b1, 0, 2'b01, 2, 8'h1C};

    cyc(3);
    chk("reset_cmd_ready", command_ready, 0);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    chk("reset_ack_valid", command_ack_valid, 0);
    chk("reset_scan_valid", scan_code_valid, 0);
    chk("reset_rx_err_code", {rx_error, rx_error_code}, 0);
    chk("reset_rx_count", rx_count, 0);
    reset_low = 1'b1;
    cyc(3);
    chk("post_reset_cmd_ready", command_ready, 1);

    for (int i = 0; i < 5; i++) begin
      e0 = err_pulses;
      send_frame(vec[i].b, vec[i].bad_par, vec[i].stop, 11);
      cyc(4);
      chk($sformatf("rx%0d_err_pulse", i), err_pulses - e0, vec[i].exp_err);
      chk($sformatf("rx%0d_err_code", i), rx_error_code, vec[i].exp_code);
      chk($sformatf("rx%0d_count", i), rx_count, vec[i].exp_cnt);
      chk($sformatf("rx%0d_head", i), scan_code_byte, vec[i].exp_head);
    end
    pop_chk("drain_head0", 8'h1C);
    chk("drain_count1", rx_count, 1);
    pop_chk("drain_head1", 8'h00);
    chk("drain_count0", rx_count, 0);
    chk("drain_valid0", scan_code_valid, 0);

    e0 = err_pulses;
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    cyc(WD + 100);
    chk("timeout_err_pulse", err_pulses - e0, 1);
    chk("timeout_err_code", rx_error_code, 2'b11);
    chk("timeout_idle_ready", command_ready, 1);
    chk("timeout_count", rx_count, 0);

    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 11);
    cyc(30);
    chk("full_count", rx_count, 4);
    chk("full_inhibit", ps2_clk_oe, 1);
    cyc(100);
    chk("full_inhibit_held", ps2_clk_oe, 1);
    pop_chk("full_pop_head", 8'h10);
    cyc(10);
    chk("full_released", ps2_clk_oe, 0);
    send_frame(8'h55, 1'b0, 1'b1, 11);
    cyc(10);
    chk("full_again_count", rx_count, 4);
    chk("full_again_inhibit", ps2_clk_oe, 1);
    pop_chk("full_d1", 8'h11);
    pop_chk("full_d2", 8'h12);
    pop_chk("full_d3", 8'h13);
    pop_chk("full_d4", 8'h55);
    cyc(10);
    chk("full_drained", rx_count, 0);

    p0 = req_pulses;
    issue_cmd(8'hED);
    dev_tx(1'b1, 10, bits, rl, sl);
    chk("tx_start_bit", sl, 0);
    chk("tx_req_len", rl, REQ);
    chk("tx_bits", bits, 10'h3ED);
    cyc(10);
    chk("tx_ack_valid", command_ack_valid, 1);
    chk("tx_ack_error", command_ack_error, 0);
    chk("tx_hold_not_ready", command_ready, 0);
    cyc(30);
    chk("tx_ack_held", command_ack_valid, 1);
    chk("tx_req_pulses", req_pulses - p0, 1);
    ack_cmd();
    chk("tx_ack_cleared", command_ack_valid, 0);
    chk("tx_ready_again", command_ready, 1);

    p0 = req_pulses;
    issue_cmd(8'h5A);
    dev_tx(1'b0, 10, bits, rl, sl);
    dev_tx(1'b0, 10, bits, rl, sl);
    dev_tx(1'b1, 10, bits, rl, sl);
    cyc(10);
    chk("retry_bits", bits, 10'h35A);
    chk("retry_pulses", req_pulses - p0, 3);
    chk("retry_ack_valid", command_ack_valid, 1);
    chk("retry_ack_error", command_ack_error, 0);
    ack_cmd();

    p0 = req_pulses;
    issue_cmd(8'h00);
    for (int a = 0; a < 3; a++) dev_tx(1'b0, 10, bits, rl, sl);
    cyc(10);
    chk("nack_ack_valid", command_ack_valid, 1);
    chk("nack_ack_error", command_ack_error, 1);
    cyc(200);
    chk("nack_pulses", req_pulses - p0, 3);
    ack_cmd();
    chk("nack_error_cleared", command_ack_error, 0);

    send_frame(8'h33, 1'b0, 1'b1, 11);
    cyc(4);
    chk("rst_pre_count", rx_count, 1);
    issue_cmd(8'h77);
    dev_tx(1'b1, 3, bits, rl, sl);
    chk("rst_in_tx_bits", ps2_data_oe, 1);
    #2 reset_low = 1'b0;
    #1;
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_ack_valid", command_ack_valid, 0);
    chk("rst_cmd_ready", command_ready, 0);
    cyc(3);
    reset_low = 1'b1;
    cyc(3);
    chk("rst_after_ready", command_ready, 1);
    chk("rst_after_count", rx_count, 0);
    chk("rst_after_valid", scan_code_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
